// File: rtl/ahb_dflt_pkg.sv
// Shared encodings and limits for the configurable AHB default slave.
package ahb_dflt_pkg;

    localparam logic [1:0] RSP_OKAY  = 2'b00;
    localparam logic [1:0] RSP_ERROR = 2'b01;

    localparam int MAX_WAIT_STATES = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2,
        ST_DONE
    } state_e;

    // A zero-wait build still needs a one-bit counter so the register exists.
    function automatic int wait_cnt_width(input int wait_states);
        int w;
        w = $clog2(wait_states + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ahb_dflt_err_log.sv
// Unmapped-access log: first-offender capture, sticky valid/overflow flags and a
// saturating access counter.
module ahb_dflt_err_log
    import ahb_dflt_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  accept,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic                  hwrite,
    input  logic                  err_clr,
    output logic                  err_valid,
    output logic                  err_ovf,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  err_write,
    output logic [CNT_WIDTH-1:0]  err_count
);

    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    // A clear that lands on the same edge as an access restarts the log with that access.
    always_comb begin
        valid_d = valid_q;
        ovf_d   = ovf_q;
        addr_d  = addr_q;
        write_d = write_q;
        count_d = count_q;
        if (accept) begin
            if (!valid_q || err_clr) begin
                addr_d  = haddr;
                write_d = hwrite;
                ovf_d   = 1'b0;
            end else begin
                ovf_d   = 1'b1;
            end
            valid_d = 1'b1;
            if (err_clr) begin
                count_d = CNT_WIDTH'(1);
            end else if (count_q != '1) begin
                count_d = count_q + CNT_WIDTH'(1);
            end
        end else if (err_clr) begin
            valid_d = 1'b0;
            ovf_d   = 1'b0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            addr_q  <= '0;
            write_q <= 1'b0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            count_q <= count_d;
        end
    end

    assign err_valid = valid_q;
    assign err_ovf   = ovf_q;
    assign err_addr  = addr_q;
    assign err_write = write_q;
    assign err_count = count_q;

endmodule

// File: rtl/ahb_default_slave_cfg.sv
// AHB default slave for unmapped addresses: programmable wait states, ERROR or
// OKAY/read-as-zero response, and an unmapped-access log for debug.
module ahb_default_slave_cfg
    import ahb_dflt_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 0,
    parameter int RESP_MODE   = 0,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  ERR_CLR,
    output logic                  ERR_VALID,
    output logic                  ERR_OVF,
    output logic [ADDR_WIDTH-1:0] ERR_ADDR,
    output logic                  ERR_WRITE,
    output logic [CNT_WIDTH-1:0]  ERR_COUNT
);

    if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT_STATES) begin : g_bad_wait_states
        $error("ahb_default_slave_cfg: WAIT_STATES must be within 0..15");
    end
    if (RESP_MODE < 0 || RESP_MODE > 1) begin : g_bad_resp_mode
        $error("ahb_default_slave_cfg: RESP_MODE must be 0 or 1");
    end

    localparam int WS_W = wait_cnt_width(WAIT_STATES);
    localparam logic [WS_W-1:0] WS_LOAD = WS_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    logic            accept;
    logic            unused_htrans0;
    state_e          state_q, state_d;
    logic [WS_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            hreadyout_q, hreadyout_d;
    logic [1:0]      hresp_q, hresp_d;

    // NONSEQ and SEQ share HTRANS[1]; IDLE and BUSY fall through with OKAY.
    assign accept         = HSEL & HREADY & HTRANS[1];
    assign unused_htrans0 = HTRANS[0];

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = (RESP_MODE == 0) ? ST_ERR1 : ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q - WS_W'(1);
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                if (accept) begin
                    wait_cnt_d = WS_LOAD;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                    end else if (RESP_MODE == 0) begin
                        state_d = ST_ERR1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        // Bus outputs follow the next state so they appear registered with it.
        hreadyout_d = 1'b1;
        hresp_d     = RSP_OKAY;
        case (state_d)
            ST_WAIT: hreadyout_d = 1'b0;
            ST_ERR1: begin
                hreadyout_d = 1'b0;
                hresp_d     = RSP_ERROR;
            end
            ST_ERR2: hresp_d = RSP_ERROR;
            default: ;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= RSP_OKAY;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = '0;

    ahb_dflt_err_log #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_err_log (
        .clk       (HCLK),
        .rst_n     (HRESETn),
        .accept    (accept),
        .haddr     (HADDR),
        .hwrite    (HWRITE),
        .err_clr   (ERR_CLR),
        .err_valid (ERR_VALID),
        .err_ovf   (ERR_OVF),
        .err_addr  (ERR_ADDR),
        .err_write (ERR_WRITE),
        .err_count (ERR_COUNT)
    );

endmodule

// File: tb/tb_ahb_default_slave_cfg.sv
// Bench for ahb_default_slave_cfg: four configurations share stimulus, each one
// closes its own HREADY loop and is tracked by a response-sequence model.
module tb_ahb_default_slave_cfg;

    localparam int NI = 4;
    // Instance order: A = mode0/WS0, B = mode0/WS3, C = mode1/WS2/CNT2, D = mode0/WS5
    localparam int WS_P   [NI] = '{0, 3, 2, 5};
    localparam int MODE_P [NI] = '{0, 0, 1, 0};
    localparam int CMAX_P [NI] = '{255, 255, 3, 255};

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [1:0]  HTRANS = 2'b00;
    logic [31:0] HADDR = 32'h0;
    logic        HWRITE = 1'b0;
    logic        ERR_CLR = 1'b0;

    logic [NI-1:0] rdy_o;
    logic [NI-1:0] valid_o;
    logic [NI-1:0] ovf_o;
    logic [NI-1:0] wr_o;
    logic [1:0]    rsp_o   [NI];
    logic [31:0]   rdata_o [NI];
    logic [31:0]   addr_o  [NI];
    logic [7:0]    cnt_o   [NI];
    logic [1:0]    cnt_c;

    int chk_cnt = 0;
    int err_cnt = 0;
    bit chk_en  = 1'b0;

    always #5 HCLK = ~HCLK;

    ahb_default_slave_cfg #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(0), .RESP_MODE(0), .CNT_WIDTH(8)) u_a (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS), .HREADY(rdy_o[0]),
        .HADDR(HADDR), .HWRITE(HWRITE), .HREADYOUT(rdy_o[0]), .HRESP(rsp_o[0]), .HRDATA(rdata_o[0]),
        .ERR_CLR(ERR_CLR), .ERR_VALID(valid_o[0]), .ERR_OVF(ovf_o[0]), .ERR_ADDR(addr_o[0]),
        .ERR_WRITE(wr_o[0]), .ERR_COUNT(cnt_o[0]));

    ahb_default_slave_cfg #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(3), .RESP_MODE(0), .CNT_WIDTH(8)) u_b (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS), .HREADY(rdy_o[1]),
        .HADDR(HADDR), .HWRITE(HWRITE), .HREADYOUT(rdy_o[1]), .HRESP(rsp_o[1]), .HRDATA(rdata_o[1]),
        .ERR_CLR(ERR_CLR), .ERR_VALID(valid_o[1]), .ERR_OVF(ovf_o[1]), .ERR_ADDR(addr_o[1]),
        .ERR_WRITE(wr_o[1]), .ERR_COUNT(cnt_o[1]));

    ahb_default_slave_cfg #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(2), .RESP_MODE(1), .CNT_WIDTH(2)) u_c (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS), .HREADY(rdy_o[2]),
        .HADDR(HADDR), .HWRITE(HWRITE), .HREADYOUT(rdy_o[2]), .HRESP(rsp_o[2]), .HRDATA(rdata_o[2]),
        .ERR_CLR(ERR_CLR), .ERR_VALID(valid_o[2]), .ERR_OVF(ovf_o[2]), .ERR_ADDR(addr_o[2]),
        .ERR_WRITE(wr_o[2]), .ERR_COUNT(cnt_c));

    ahb_default_slave_cfg #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(5), .RESP_MODE(0), .CNT_WIDTH(8)) u_d (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS), .HREADY(rdy_o[3]),
        .HADDR(HADDR), .HWRITE(HWRITE), .HREADYOUT(rdy_o[3]), .HRESP(rsp_o[3]), .HRDATA(rdata_o[3]),
        .ERR_CLR(ERR_CLR), .ERR_VALID(valid_o[3]), .ERR_OVF(ovf_o[3]), .ERR_ADDR(addr_o[3]),
        .ERR_WRITE(wr_o[3]), .ERR_COUNT(cnt_o[3]));

    assign cnt_o[2] = {6'd0, cnt_c};

    // Model: each accept queues the per-cycle {HREADYOUT, ERROR} pattern of its data phase.
    logic [1:0]  pend [NI][$];
    logic        m_rdy   [NI];
    logic [1:0]  m_rsp   [NI];
    logic        m_valid [NI];
    logic        m_ovf   [NI];
    logic        m_wr    [NI];
    logic [31:0] m_addr  [NI];
    int          m_cnt   [NI];
    logic        acc_m;
    logic [1:0]  ent_m;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < NI; i++) begin
                pend[i].delete();
                m_rdy[i] = 1'b1;   m_rsp[i] = 2'b00;
                m_valid[i] = 1'b0; m_ovf[i] = 1'b0;
                m_wr[i] = 1'b0;    m_addr[i] = 32'h0;  m_cnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                acc_m = HSEL && m_rdy[i] && HTRANS[1];
                if (acc_m) begin
                    for (int k = 0; k < WS_P[i]; k++) pend[i].push_back(2'b00);
                    if (MODE_P[i] == 0) begin
                        pend[i].push_back(2'b01);
                        pend[i].push_back(2'b11);
                    end else begin
                        pend[i].push_back(2'b10);
                    end
                end
                if (pend[i].size() != 0) begin
                    ent_m = pend[i].pop_front();
                    m_rdy[i] = ent_m[1];
                    m_rsp[i] = {1'b0, ent_m[0]};
                end else begin
                    m_rdy[i] = 1'b1;
                    m_rsp[i] = 2'b00;
                end
                if (acc_m) begin
                    if (ERR_CLR || !m_valid[i]) begin
                        m_addr[i] = HADDR; m_wr[i] = HWRITE; m_ovf[i] = 1'b0;
                    end else begin
                        m_ovf[i] = 1'b1;
                    end
                    m_valid[i] = 1'b1;
                    m_cnt[i] = ERR_CLR ? 1 : ((m_cnt[i] + 1 > CMAX_P[i]) ? CMAX_P[i] : m_cnt[i] + 1);
                end else if (ERR_CLR) begin
                    m_valid[i] = 1'b0; m_ovf[i] = 1'b0; m_cnt[i] = 0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s inst=%0d t=%0t actual=%0h required=%0h", name, idx, $time, act, exp);
        end
    endtask

    always @(negedge HCLK) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                checkOutput("HREADYOUT", i, 64'(rdy_o[i]),   64'(m_rdy[i]));
                checkOutput("HRESP",     i, 64'(rsp_o[i]),   64'(m_rsp[i]));
                checkOutput("HRDATA",    i, 64'(rdata_o[i]), 64'h0);
                checkOutput("ERR_VALID", i, 64'(valid_o[i]), 64'(m_valid[i]));
                checkOutput("ERR_OVF",   i, 64'(ovf_o[i]),   64'(m_ovf[i]));
                checkOutput("ERR_ADDR",  i, 64'(addr_o[i]),  64'(m_addr[i]));
                checkOutput("ERR_WRITE", i, 64'(wr_o[i]),    64'(m_wr[i]));
                checkOutput("ERR_COUNT", i, 64'(cnt_o[i]),   64'(m_cnt[i]));
            end
        end
    end

    task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                                 input logic wr, input logic clr);
        @(negedge HCLK);
        HSEL = sel; HTRANS = trans; HADDR = addr; HWRITE = wr; ERR_CLR = clr;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        $display("[TB] start");
        idleCycles(3);
        HRESETn = 1'b1;
        chk_en  = 1'b1;
        checkOutput("lit_rst_rdy", 0, 64'(rdy_o[0]), 64'd1);
        checkOutput("lit_rst_rsp", 0, 64'(rsp_o[0]), 64'd0);
        checkOutput("lit_rst_valid", 0, 64'(valid_o[0]), 64'd0);
        checkOutput("lit_rst_cnt", 0, 64'(cnt_o[0]), 64'd0);
        idleCycles(2);

        // Single NONSEQ read, all instances accept together.
        applyStimulus(1'b1, 2'b10, 32'h4000_0000, 1'b0, 1'b0);
        idleCycles(1);
        checkOutput("lit_a_c1_rdy", 0, 64'(rdy_o[0]), 64'd0);
        checkOutput("lit_a_c1_rsp", 0, 64'(rsp_o[0]), 64'd1);
        checkOutput("lit_a_addr", 0, 64'(addr_o[0]), 64'h4000_0000);
        checkOutput("lit_a_valid", 0, 64'(valid_o[0]), 64'd1);
        checkOutput("lit_a_cnt", 0, 64'(cnt_o[0]), 64'd1);
        checkOutput("lit_b_c1_rsp", 1, 64'(rsp_o[1]), 64'd0);
        idleCycles(1);
        checkOutput("lit_a_c2_rdy", 0, 64'(rdy_o[0]), 64'd1);
        checkOutput("lit_a_c2_rsp", 0, 64'(rsp_o[0]), 64'd1);
        idleCycles(2);
        checkOutput("lit_b_c4_rdy", 1, 64'(rdy_o[1]), 64'd0);
        checkOutput("lit_b_c4_rsp", 1, 64'(rsp_o[1]), 64'd1);
        idleCycles(1);
        checkOutput("lit_b_c5_rdy", 1, 64'(rdy_o[1]), 64'd1);
        checkOutput("lit_b_c5_rsp", 1, 64'(rsp_o[1]), 64'd1);
        idleCycles(4);

        // Clear alone keeps the captured address; then write followed by held SEQ read.
        applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 1'b1);
        idleCycles(1);
        checkOutput("lit_clr_valid", 2, 64'(valid_o[2]), 64'd0);
        checkOutput("lit_clr_cnt", 2, 64'(cnt_o[2]), 64'd0);
        checkOutput("lit_clr_addr", 2, 64'(addr_o[2]), 64'h4000_0000);
        applyStimulus(1'b1, 2'b10, 32'h2000_0004, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b11, 32'h2000_0008, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b11, 32'h2000_0008, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b11, 32'h2000_0008, 1'b0, 1'b0);
        checkOutput("lit_a_b2b_rdy", 0, 64'(rdy_o[0]), 64'd0);
        checkOutput("lit_a_b2b_rsp", 0, 64'(rsp_o[0]), 64'd1);
        checkOutput("lit_c_done_rdy", 2, 64'(rdy_o[2]), 64'd1);
        checkOutput("lit_c_done_rsp", 2, 64'(rsp_o[2]), 64'd0);
        idleCycles(3);
        checkOutput("lit_c_rd_rdy", 2, 64'(rdy_o[2]), 64'd1);
        checkOutput("lit_c_cnt", 2, 64'(cnt_o[2]), 64'd2);
        checkOutput("lit_c_ovf", 2, 64'(ovf_o[2]), 64'd1);
        checkOutput("lit_c_write", 2, 64'(wr_o[2]), 64'd1);
        checkOutput("lit_c_addr", 2, 64'(addr_o[2]), 64'h2000_0004);
        idleCycles(8);

        // Selected IDLE and BUSY are not accepted.
        applyStimulus(1'b1, 2'b00, 32'h0000_1234, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 32'h0000_1234, 1'b0, 1'b0);
        checkOutput("lit_idle_rdy", 0, 64'(rdy_o[0]), 64'd1);
        idleCycles(1);
        checkOutput("lit_busy_rdy", 0, 64'(rdy_o[0]), 64'd1);
        checkOutput("lit_busy_rsp", 0, 64'(rsp_o[0]), 64'd0);
        checkOutput("lit_busy_cnt", 0, 64'(cnt_o[0]), 64'd2);

        // Counter saturation on the 2-bit instance: five accepts.
        applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 15; k++) applyStimulus(1'b1, 2'b10, 32'h0000_0100, 1'b0, 1'b0);
        idleCycles(8);
        checkOutput("lit_c_sat", 2, 64'(cnt_o[2]), 64'd3);
        checkOutput("lit_a_cnt8", 0, 64'(cnt_o[0]), 64'd8);

        // Clear coincident with an accept: the accept wins.
        applyStimulus(1'b1, 2'b10, 32'h0000_0010, 1'b1, 1'b1);
        idleCycles(1);
        checkOutput("lit_cc_cnt", 0, 64'(cnt_o[0]), 64'd1);
        checkOutput("lit_cc_addr", 0, 64'(addr_o[0]), 64'h10);
        checkOutput("lit_cc_ovf", 0, 64'(ovf_o[0]), 64'd0);
        checkOutput("lit_cc_c_cnt", 2, 64'(cnt_o[2]), 64'd1);
        idleCycles(8);

        // Reset in the middle of D's wait phase.
        applyStimulus(1'b1, 2'b10, 32'h3000_0000, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("lit_d_wait", 3, 64'(rdy_o[3]), 64'd0);
        #2 HRESETn = 1'b0;
        #1;
        checkOutput("lit_d_rst_rdy", 3, 64'(rdy_o[3]), 64'd1);
        checkOutput("lit_d_rst_rsp", 3, 64'(rsp_o[3]), 64'd0);
        checkOutput("lit_d_rst_valid", 3, 64'(valid_o[3]), 64'd0);
        checkOutput("lit_d_rst_cnt", 3, 64'(cnt_o[3]), 64'd0);
        idleCycles(1);
        HRESETn = 1'b1;
        applyStimulus(1'b1, 2'b10, 32'h5000_0000, 1'b1, 1'b0);
        idleCycles(1);
        checkOutput("lit_d_new_rdy", 3, 64'(rdy_o[3]), 64'd0);
        checkOutput("lit_d_new_addr", 3, 64'(addr_o[3]), 64'h5000_0000);
        checkOutput("lit_d_new_cnt", 3, 64'(cnt_o[3]), 64'd1);
        idleCycles(9);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ahb_default_slave_cfg.md
Name: ahb_default_slave_cfg

Overview:
Parametrised default slave for the generated AHB bus matrices; answers every transfer that decodes to no mapped slave. It adds programmable wait states, a selectable response mode (ERROR or OKAY/read-as-zero) and an unmapped-access log with a sticky flag for a debug interrupt. It is instantiated per matrix output in place of the fixed two-cycle error slave.

Parameters:
ADDR_WIDTH, 32, width of HADDR and captured address
DATA_WIDTH, 32, width of HRDATA
WAIT_STATES, 0, HREADYOUT-low cycles before the response phase (0..15)
RESP_MODE, 0, 0 = two-cycle ERROR response; 1 = OKAY response, HRDATA = 0, writes ignored
CNT_WIDTH, 8, width of the saturating unmapped-access counter

Ports:
HCLK  in  1  AHB system clock
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select
HTRANS  in  2  transfer type
HREADY  in  1  bus transfer done
HADDR  in  ADDR_WIDTH  address, sampled in address phase
HWRITE  in  1  write indicator, sampled in address phase
HREADYOUT  out  1  HREADY feedback
HRESP  out  2  response (00 OKAY, 01 ERROR)
HRDATA  out  DATA_WIDTH  read data, constant zero
ERR_CLR  in  1  single-cycle pulse; clears the log
ERR_VALID  out  1  sticky: at least one unmapped access since clear
ERR_OVF  out  1  sticky: a further access arrived while ERR_VALID was set
ERR_ADDR  out  ADDR_WIDTH  address of the first unmapped access since clear
ERR_WRITE  out  1  HWRITE of that access
ERR_COUNT  out  CNT_WIDTH  accesses since clear, saturating

Behaviour:
- Accept = HSEL & HREADY & HTRANS[1] at a rising HCLK edge. IDLE and BUSY transfers are never accepted; they get a zero-wait OKAY.
- The FSM has five states: IDLE, WAIT, ERR1, ERR2, DONE. All outputs are registered.
- HREADYOUT/HRESP by state:
  - IDLE: 1/OKAY
  - WAIT: 0/OKAY
  - ERR1: 0/ERROR
  - ERR2: 1/ERROR
  - DONE: 1/OKAY
- Wait counter: WS_W = max(1, $clog2(WAIT_STATES+1)) bits. It loads WAIT_STATES-1 on entry to WAIT and decrements each cycle. When it reaches 0, WAIT exits to ERR1 (mode 0) or DONE (mode 1).
- Transitions from IDLE, ERR2 or DONE on accept:
  - WAIT_STATES>0: go to WAIT.
  - WAIT_STATES=0, mode 0: go to ERR1.
  - WAIT_STATES=0, mode 1: go to DONE.
- Without accept, IDLE, ERR2 and DONE return to IDLE. ERR1 always goes to ERR2.
- Accept is impossible in WAIT and ERR1 because HREADY is low there. Back-to-back accepts in ERR2 or DONE are required and restart the sequence with no idle cycle.
- Latency from accepting edge: mode 0 completes after WAIT_STATES+2 data-phase cycles; mode 1 after WAIT_STATES+1 cycles. With WAIT_STATES=0, mode 0 is cycle-identical to the legacy default slave.
- HRDATA is tied to 0. Write data is not observed.
- Log: on every accept (both modes) ERR_COUNT increments and saturates at 2^CNT_WIDTH-1.
  - If ERR_VALID=0, capture HADDR/HWRITE into ERR_ADDR/ERR_WRITE and set ERR_VALID.
  - If ERR_VALID=1, set ERR_OVF and leave ERR_ADDR unchanged.
- ERR_CLR alone: ERR_VALID, ERR_OVF and ERR_COUNT go to 0; ERR_ADDR/ERR_WRITE hold their last value.
- ERR_CLR coincident with accept: the accept wins. Result is capture of the new access, ERR_VALID=1, ERR_OVF=0, ERR_COUNT=1.
- Reset, at any time including mid-sequence:
  - FSM returns to IDLE, HREADYOUT=1, HRESP=OKAY.
  - All log outputs go to 0.
  - No response is completed for an in-flight transfer.
- Elaboration: WAIT_STATES>15 or RESP_MODE>1 is rejected with a generate-time error.

Decomposition:
- Package ahb_dflt_pkg holds the HRESP encodings (RSP_OKAY=2'b00, RSP_ERROR=2'b01), the FSM state encoding and the WAIT_STATES limit.
- Sub-module ahb_dflt_err_log contains the capture registers, sticky flags and saturating counter. Its inputs are accept, HADDR, HWRITE and ERR_CLR.
- The FSM and wait counter stay in the top module.

Test Plan:
- Mode 0, WS=0: NONSEQ to 0x4000_0000 → next cycle HREADYOUT=0/ERROR, then 1/ERROR. ERR_ADDR=0x4000_0000, ERR_VALID=1, ERR_COUNT=1.
- Mode 0, WS=3: single read → 3 cycles 0/OKAY, then ERR1, ERR2; total 5 data-phase cycles.
- Mode 1, WS=2: write then read → each gets 2 wait cycles and completes 1/OKAY with HRDATA=0. ERR_COUNT=2, ERR_OVF=1, ERR_WRITE=1.
- Back-to-back: SEQ presented during ERR2 → accepted and ERR1 follows immediately. IDLE or BUSY with HSEL=1 → HREADYOUT stays 1/OKAY and ERR_COUNT is unchanged.
- Log boundaries: CNT_WIDTH=2 with 5 accepts → ERR_COUNT=3. ERR_CLR on the same edge as an accept to 0x10 → ERR_COUNT=1, ERR_ADDR=0x10, ERR_OVF=0.
- Reset asserted in WAIT (WS=5, cycle 2) → HREADYOUT=1 and HRESP=OKAY immediately, log cleared. After release a new accept behaves normally.
